lifo_stack: RTL and testbench

- Parametrised hardware LIFO for the processor's call/return and operand stacks.
- Adds the following:
  - configurable width and depth
  - explicit full/empty/count status
  - sticky overflow/underflow error flags
  - same-cycle push+pop (replace top)
  - selectable overflow policy: reject, or circular overwrite of the oldest entry
- Sits between the control unit and the PC/ALU datapath.

---
 rtl/lifo_stack.sv | 129 ++++++++++++
 tb/tb_lifo_stack.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/lifo_stack.sv
// Parametrised LIFO for call/return and operand stacks: push, pop, replace-top,
// full/empty/count status, sticky overflow/underflow and a selectable overflow policy.
module lifo_stack #(
    parameter int D_WIDTH   = 12,
    parameter int DEPTH     = 8,
    parameter int PTR_W     = 3,
    parameter int CNT_W     = 4,
    parameter int WRAP_MODE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [D_WIDTH-1:0] data_in,
    input  logic               err_clr,
    output logic [D_WIDTH-1:0] data_out,
    output logic [CNT_W-1:0]   count,
    output logic               empty,
    output logic               full,
    output logic               overflow,
    output logic               underflow
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               WRAP     = (WRAP_MODE != 0);

    logic [D_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   top;
    logic [PTR_W-1:0]   top_next;
    logic [CNT_W-1:0]   count_next;
    logic [PTR_W-1:0]   wr_addr;
    logic               wr_en;
    logic               ovf_event;
    logic               unf_event;
    logic               is_empty;
    logic               is_full;

    assign is_empty = (count == '0);
    assign is_full  = (count == CNT_FULL);
    assign empty    = is_empty;
    assign full     = is_full;
    assign data_out = is_empty ? '0 : mem[top];

    // Exactly one case applies per edge; pointer arithmetic wraps naturally at PTR_W bits.
    always_comb begin
        top_next   = top;
        count_next = count;
        wr_addr    = top + PTR_ONE;
        wr_en      = 1'b0;
        ovf_event  = 1'b0;
        unf_event  = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (!is_full) begin
                    wr_en      = 1'b1;
                    top_next   = top + PTR_ONE;
                    count_next = count + CNT_ONE;
                end else begin
                    ovf_event = 1'b1;
                    if (WRAP) begin
                        // The slot after top holds the oldest entry when full; it is overwritten.
                        wr_en    = 1'b1;
                        top_next = top + PTR_ONE;
                    end
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    top_next   = top - PTR_ONE;
                    count_next = count - CNT_ONE;
                end else begin
                    unf_event = 1'b1;
                end
            end
            2'b11: begin
                if (is_empty) begin
                    wr_en      = 1'b1;
                    top_next   = top + PTR_ONE;
                    count_next = CNT_ONE;
                    unf_event  = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = top;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            top   <= '0;
            count <= '0;
        end else begin
            top   <= top_next;
            count <= count_next;
        end
    end

    // Storage is deliberately left out of reset; stale words are masked by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    // A new error on the same edge as err_clr takes priority.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (unf_event) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: a reject-mode and a wrap-mode instance (DEPTH=4)
// share the same stimulus and are each compared against hand-computed values.
module tb_lifo_stack;

    localparam int DW = 12;
    localparam int DP = 4;
    localparam int PW = 2;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          push;
    logic          pop;
    logic [DW-1:0] data_in;
    logic          err_clr;

    logic [DW-1:0] rej_data, wrap_data;
    logic [CW-1:0] rej_count, wrap_count;
    logic          rej_empty, wrap_empty, rej_full, wrap_full;
    logic          rej_ovf, wrap_ovf, rej_unf, wrap_unf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lifo_stack #(.D_WIDTH(DW), .DEPTH(DP), .PTR_W(PW), .CNT_W(CW), .WRAP_MODE(0)) u_rej (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .err_clr(err_clr), .data_out(rej_data), .count(rej_count), .empty(rej_empty),
        .full(rej_full), .overflow(rej_ovf), .underflow(rej_unf)
    );

    lifo_stack #(.D_WIDTH(DW), .DEPTH(DP), .PTR_W(PW), .CNT_W(CW), .WRAP_MODE(1)) u_wrap (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .err_clr(err_clr), .data_out(wrap_data), .count(wrap_count), .empty(wrap_empty),
        .full(wrap_full), .overflow(wrap_ovf), .underflow(wrap_unf)
    );

    typedef struct {
        logic          push;
        logic          pop;
        logic [DW-1:0] din;
        logic          clr;
        logic [DW-1:0] d_rej;
        logic [CW-1:0] c_rej;
        logic [DW-1:0] d_wrap;
        logic [CW-1:0] c_wrap;
        logic          ovf;
        logic          unf;
    } vec_t;

    vec_t vecs[$];

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [DW-1:0] d_rej, input logic [CW-1:0] c_rej,
                               input logic [DW-1:0] d_wrap, input logic [CW-1:0] c_wrap,
                               input logic ovf, input logic unf);
        checkVal({tag, " rej.data_out"}, int'(rej_data), int'(d_rej));
        checkVal({tag, " rej.count"}, int'(rej_count), int'(c_rej));
        checkVal({tag, " rej.empty"}, int'(rej_empty), int'(c_rej == 0));
        checkVal({tag, " rej.full"}, int'(rej_full), int'(c_rej == CW'(DP)));
        checkVal({tag, " rej.overflow"}, int'(rej_ovf), int'(ovf));
        checkVal({tag, " rej.underflow"}, int'(rej_unf), int'(unf));
        checkVal({tag, " wrap.data_out"}, int'(wrap_data), int'(d_wrap));
        checkVal({tag, " wrap.count"}, int'(wrap_count), int'(c_wrap));
        checkVal({tag, " wrap.empty"}, int'(wrap_empty), int'(c_wrap == 0));
        checkVal({tag, " wrap.full"}, int'(wrap_full), int'(c_wrap == CW'(DP)));
        checkVal({tag, " wrap.overflow"}, int'(wrap_ovf), int'(ovf));
        checkVal({tag, " wrap.underflow"}, int'(wrap_unf), int'(unf));
    endtask

    task automatic applyStimulus(input logic p, input logic q, input logic [DW-1:0] d, input logic c);
        push    = p;
        pop     = q;
        data_in = d;
        err_clr = c;
        @(posedge clk);
        #1;
        push    = 1'b0;
        pop     = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic addVec(input logic p, input logic q, input logic [DW-1:0] d, input logic c,
                          input logic [DW-1:0] dr, input logic [CW-1:0] cr,
                          input logic [DW-1:0] dw, input logic [CW-1:0] cw,
                          input logic o, input logic u);
        vec_t v;
        v = '{push: p, pop: q, din: d, clr: c, d_rej: dr, c_rej: cr, d_wrap: dw, c_wrap: cw, ovf: o, unf: u};
        vecs.push_back(v);
    endtask

    initial begin
        // Basic push/pop ordering
        addVec(1, 0, 12'h111, 0, 12'h111, 1, 12'h111, 1, 0, 0);
        addVec(1, 0, 12'h222, 0, 12'h222, 2, 12'h222, 2, 0, 0);
        addVec(1, 0, 12'h333, 0, 12'h333, 3, 12'h333, 3, 0, 0);
        addVec(0, 1, 12'h000, 0, 12'h222, 2, 12'h222, 2, 0, 0);
        addVec(0, 1, 12'h000, 0, 12'h111, 1, 12'h111, 1, 0, 0);
        addVec(0, 1, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        // Fill, then push while full: the two policies diverge
        addVec(1, 0, 12'hA01, 0, 12'hA01, 1, 12'hA01, 1, 0, 0);
        addVec(1, 0, 12'hA02, 0, 12'hA02, 2, 12'hA02, 2, 0, 0);
        addVec(1, 0, 12'hA03, 0, 12'hA03, 3, 12'hA03, 3, 0, 0);
        addVec(1, 0, 12'hA04, 0, 12'hA04, 4, 12'hA04, 4, 0, 0);
        addVec(1, 0, 12'hBBB, 0, 12'hA04, 4, 12'hBBB, 4, 1, 0);
        addVec(0, 1, 12'h000, 0, 12'hA03, 3, 12'hA04, 3, 1, 0);
        addVec(0, 1, 12'h000, 0, 12'hA02, 2, 12'hA03, 2, 1, 0);
        addVec(0, 1, 12'h000, 0, 12'hA01, 1, 12'hA02, 1, 1, 0);
        addVec(0, 1, 12'h000, 0, 12'h000, 0, 12'h000, 0, 1, 0);
        addVec(0, 0, 12'h000, 1, 12'h000, 0, 12'h000, 0, 0, 0);
        // Replace top
        addVec(1, 0, 12'h010, 0, 12'h010, 1, 12'h010, 1, 0, 0);
        addVec(1, 0, 12'h020, 0, 12'h020, 2, 12'h020, 2, 0, 0);
        addVec(1, 1, 12'h0FF, 0, 12'h0FF, 2, 12'h0FF, 2, 0, 0);
        addVec(0, 1, 12'h000, 0, 12'h010, 1, 12'h010, 1, 0, 0);
        addVec(0, 1, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0, 0);
        // Underflow, clear, push+pop while empty, set-wins-over-clear
        addVec(0, 1, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0, 1);
        addVec(0, 0, 12'h000, 1, 12'h000, 0, 12'h000, 0, 0, 0);
        addVec(1, 1, 12'h055, 0, 12'h055, 1, 12'h055, 1, 0, 1);
        addVec(0, 1, 12'h000, 1, 12'h000, 0, 12'h000, 0, 0, 0);
        addVec(0, 1, 12'h000, 1, 12'h000, 0, 12'h000, 0, 0, 1);
        addVec(0, 0, 12'h000, 1, 12'h000, 0, 12'h000, 0, 0, 0);
        // Replace top while full raises no overflow; then overflow before reset test
        addVec(1, 0, 12'h001, 0, 12'h001, 1, 12'h001, 1, 0, 0);
        addVec(1, 0, 12'h002, 0, 12'h002, 2, 12'h002, 2, 0, 0);
        addVec(1, 0, 12'h003, 0, 12'h003, 3, 12'h003, 3, 0, 0);
        addVec(1, 0, 12'h004, 0, 12'h004, 4, 12'h004, 4, 0, 0);
        addVec(1, 1, 12'h0AB, 0, 12'h0AB, 4, 12'h0AB, 4, 0, 0);
        addVec(1, 0, 12'hCCC, 0, 12'h0AB, 4, 12'hCCC, 4, 1, 0);

        reset   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        data_in = '0;
        err_clr = 1'b0;
        #12;
        checkOutput("reset", 12'h000, 0, 12'h000, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].din, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].d_rej, vecs[i].c_rej,
                        vecs[i].d_wrap, vecs[i].c_wrap, vecs[i].ovf, vecs[i].unf);
        end

        // Asynchronous reset between edges clears state without a clock
        #3;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", 12'h000, 0, 12'h000, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1, 0, 12'h777, 0);
        checkOutput("after_reset", 12'h777, 1, 12'h777, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
